ram_pg_ctrl: RTL



---
 rtl/ram_pg_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ram_pg_ctrl.sv
// ram_pg_ctrl: power-gate sequencer and post-wake re-init walker for a 1R1W RAM.
// Owns the RAM write port and gate input; blocks functional writes while gated or rebuilding.
// Optional feature macro: RAM_PG_SETTLE_EN inserts a settle window between gate release and init.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (shared with the RAM)
//   pwrDownReq_i        : level request, 1 = gate the RAM
//   we_i/addrWr_i/data_i: functional write request
//   pwrGate_o           : RAM gate input
//   ramWe_o/ramAddrWr_o/ramData_o : RAM write port
//   ready_o             : RAM powered and contents valid
//   busy_o              : settling or re-initializing
//   wrDropped_o         : one-cycle pulse, a functional write was discarded
module ram_pg_ctrl #(
    parameter int DEPTH         = 64,
    parameter int INDEX         = 6,
    parameter int WIDTH         = 32,
    parameter int INIT_MODE     = 0,
    parameter int SEQ_START     = 0,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwrDownReq_i,
    input  logic             we_i,
    input  logic [INDEX-1:0] addrWr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             pwrGate_o,
    output logic             ramWe_o,
    output logic [INDEX-1:0] ramAddrWr_o,
    output logic [WIDTH-1:0] ramData_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             wrDropped_o
);

    // One counter serves both the settle countdown and the init walk,
    // so it must be wide enough for whichever is larger.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CW = (INDEX > SW) ? INDEX : SW;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_ON,
        ST_OFF,
        ST_SETTLE,
        ST_INIT
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            accept;
    logic            drop_d;
    logic            ram_we_d;
    logic [INDEX-1:0] addr_d;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_ON: begin
                if (pwrDownReq_i) begin
                    state_d = ST_OFF;
                end else begin
                    accept = we_i;
                end
            end
            ST_OFF: begin
                if (!pwrDownReq_i) begin
`ifdef RAM_PG_SETTLE_EN
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(SETTLE_CYCLES - 1);
`else
                    state_d = ST_INIT;
                    cnt_d   = '0;
`endif
                end
            end
`ifdef RAM_PG_SETTLE_EN
            ST_SETTLE: begin
                if (pwrDownReq_i) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            ST_INIT: begin
                if (pwrDownReq_i) begin
                    // Abort discards progress; next wake rebuilds from entry 0.
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_ON;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered images of the next state, so the
        // write port and status lines change on the same edge as state.
        drop_d   = we_i && !accept;
        ram_we_d = accept || (state_d == ST_INIT);
        addr_d   = ramAddrWr_o;
        data_d   = ramData_o;
        if (state_d == ST_INIT) begin
            addr_d = INDEX'(cnt_d);
            data_d = (INIT_MODE == 0) ? '0
                   : WIDTH'(SEQ_START) + WIDTH'(cnt_d);
        end else if (accept) begin
            addr_d = addrWr_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ON;
            cnt_q       <= '0;
            pwrGate_o   <= 1'b0;
            ramWe_o     <= 1'b0;
            ramAddrWr_o <= '0;
            ramData_o   <= '0;
            ready_o     <= 1'b1;
            busy_o      <= 1'b0;
            wrDropped_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwrGate_o   <= (state_d == ST_OFF);
            ramWe_o     <= ram_we_d;
            ramAddrWr_o <= addr_d;
            ramData_o   <= data_d;
            ready_o     <= (state_d == ST_ON);
            busy_o      <= (state_d == ST_SETTLE) || (state_d == ST_INIT);
            wrDropped_o <= drop_d;
        end
    end

endmodule
